input_shift_register: RTL
=========================

// Module: input_shift_register
// PURPOSE
//  Receive-side counterpart of the OSR: 32-bit ISR of one PIO state machine. Serves IN (shift bits in),
//  PUSH (send ISR to RX FIFO) and MOV ISR,src. Autopush sends ISR to the RX FIFO once the shift threshold
//  is reached. Sits between the instruction decoder/pin mux (in_data) and the per-SM RX FIFO.
// PARAMETERS
//  none (width fixed at 32; shared constants in pio_pkg)
// PORTS
//  clk                  in   1   clock; everything is on posedge clk
//  rst                  in   1   reset, synchronous, active-high
//  in_data              in   32  IN source value; bits [n-1:0] are used
//  in_en                in   1   IN instruction executes this cycle
//  bit_count            in   5   IN bit count n; 0 encodes 32
//  shiftdir             in   1   0 = shift left, 1 = shift right
//  autopush             in   1   autopush enable (SHIFTCTRL)
//  push_thresh          in   5   autopush/iffull threshold; 0 encodes 32
//  push_en              in   1   PUSH instruction executes this cycle
//  push_iffull          in   1   PUSH only if input_shift_counter >= threshold
//  push_block           in   1   PUSH stalls while RX FIFO full
//  mov_en               in   1   MOV ISR,src this cycle
//  mov_in               in   32  MOV source value
//  fifo_full            in   1   RX FIFO full
//  fifo_push            out  1   combinational; RX FIFO captures fifo_wdata on this clk edge
//  fifo_wdata           out  32  combinational; data pushed
//  stall                out  1   combinational; instruction must be held and re-issued
//  rx_overflow          out  1   registered 1-cycle pulse; non-blocking PUSH dropped data
//  isr_out              out  32  current ISR (MOV dst,ISR / IN ISR source)
//  input_shift_counter  out  6   bits shifted in since last clear; 0 = empty, saturates at 32
// BEHAVIOUR
//  Reset: ISR=0, counter=0, rx_overflow=0. While rst is high, fifo_push=0 and stall=0.
//  Reset mid-instruction aborts it; no push is issued.
//  Priority when strobes overlap: mov_en > push_en > in_en. The decoder never overlaps them.
//  thr = push_thresh ? push_thresh : 32.  n = bit_count ? bit_count : 32.
//  cnt' = min(counter+n, 32), computed with a 7-bit sum.
//  MOV: ISR<=mov_in; counter<=0; no push, no stall.
//  IN, shiftdir=0: s = (ISR<<n) | in_data[n-1:0].
//  IN, shiftdir=1: s = (ISR>>n) | (in_data[n-1:0]<<(32-n)).
//  IN, n=32: s = in_data in either direction.
//  IN without autopush fire: ISR<=s; counter<=cnt'.
//  IN autopush fire = autopush && cnt'>=thr:
//   - FIFO not full: fifo_push=1, fifo_wdata=s, ISR<=0, counter<=0, same cycle.
//   - FIFO full: stall=1; ISR and counter unchanged.
//  PUSH: skipped (no-op, no stall) if push_iffull && counter<thr. Otherwise:
//   - FIFO not full: fifo_push=1, fifo_wdata=ISR, ISR<=0, counter<=0.
//   - FIFO full, push_block=1: stall=1; state unchanged.
//   - FIFO full, push_block=0: no push; ISR<=0; counter<=0; rx_overflow<=1 for one cycle.
//  A stalled instruction has no side effects. It completes in the first cycle fifo_full=0.
// CONFIGURATION
//  PIO_ISR_AUTOPUSH_EN defined: autopush behaves as above.
//  PIO_ISR_AUTOPUSH_EN undefined: autopush input ignored; IN never pushes or stalls;
//   the counter still saturates at 32.
// STRUCTURE
//  pio_pkg: PIO_DATA_W=32, PIO_CNT_W=6, shiftdir_e {SHIFT_LEFT=0, SHIFT_RIGHT=1},
//   function decode_count(5b) -> 6b (0 encodes 32).
//  Sub-module isr_shift_merge: combinational (isr, in_data, n, dir) -> s. Shared later with MOV/IN
//   bit-reverse paths.
//  Top holds the ISR and counter registers, the push/stall decision and rx_overflow.
// TESTING
//  1 shiftdir=0, n=8, in_data=0xAB, then n=8, 0xCD -> ISR=0x0000ABCD, counter=16, no push.
//  2 shiftdir=1, n=4, in_data=0xF, ISR=0 -> ISR=0xF0000000, counter=4.
//  3 autopush, thr=8, shiftdir=0, two IN n=4 of 0x3,0x5 -> 2nd cycle fifo_push=1,
//    fifo_wdata=0x35, ISR=0, counter=0.
//  4 same as 3 with fifo_full=1 for 3 cycles -> stall=1 for 3 cycles, ISR=0x3;
//    push when full drops.
//  5 PUSH noblock, fifo_full=1, ISR=0x1234 -> no push, rx_overflow pulse, ISR=0, counter=0.
//  6 PUSH iffull, thr=16, counter=8 -> no-op, no stall; MOV 0xDEADBEEF -> ISR loaded,
//    counter=0; rst mid-stall -> all cleared.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared PIO constants, shift-direction type and count decoding.
package pio_pkg;

  localparam int unsigned PIO_DATA_W = 32;
  localparam int unsigned PIO_CNT_W  = 6;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shiftdir_e;

  // 5-bit count/threshold field where 0 encodes the full width of 32.
  function automatic logic [PIO_CNT_W-1:0] decode_count(input logic [4:0] c);
    return (c == 5'd0) ? PIO_CNT_W'(PIO_DATA_W) : PIO_CNT_W'(c);
  endfunction

endpackage

// File: rtl/isr_shift_merge.sv
// Combinational ISR shift/merge: shifts the ISR by n and inserts in_data[n-1:0]
// at the vacated end. n is 1..32; n=32 yields in_data in both directions.
module isr_shift_merge
  import pio_pkg::*;
(
  input  logic [PIO_DATA_W-1:0] i_isr,
  input  logic [PIO_DATA_W-1:0] i_in_data,
  input  logic [PIO_CNT_W-1:0]  i_n,
  input  shiftdir_e             i_dir,
  output logic [PIO_DATA_W-1:0] o_merged_c
);

  logic [PIO_DATA_W-1:0] w_mask;
  logic [PIO_DATA_W-1:0] w_field;

  // Shifting by 32 yields zero, so the mask becomes all ones for n=32.
  assign w_mask  = ~({PIO_DATA_W{1'b1}} << i_n);
  assign w_field = i_in_data & w_mask;

  // Merge the new field into the shifted ISR according to direction.
  always_comb begin
    o_merged_c = (i_isr << i_n) | w_field;
    if (i_dir == SHIFT_RIGHT) begin
      o_merged_c = (i_isr >> i_n) | (w_field << (PIO_CNT_W'(PIO_DATA_W) - i_n));
    end
  end

endmodule

// File: rtl/input_shift_register.sv
// PIO input shift register: IN shifting, PUSH, MOV ISR,src and autopush to the
// RX FIFO. Optional feature macro: PIO_ISR_AUTOPUSH_EN (autopush honoured when
// defined; otherwise the autopush input is ignored and IN never pushes/stalls).
module input_shift_register
  import pio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIO_DATA_W-1:0] in_data,
  input  logic                  in_en,
  input  logic [4:0]            bit_count,
  input  logic                  shiftdir,
  input  logic                  autopush,
  input  logic [4:0]            push_thresh,
  input  logic                  push_en,
  input  logic                  push_iffull,
  input  logic                  push_block,
  input  logic                  mov_en,
  input  logic [PIO_DATA_W-1:0] mov_in,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [PIO_DATA_W-1:0] fifo_wdata,
  output logic                  stall,
  output logic                  rx_overflow,
  output logic [PIO_DATA_W-1:0] isr_out,
  output logic [PIO_CNT_W-1:0]  input_shift_counter
);

  logic [PIO_DATA_W-1:0] r_isr;
  logic [PIO_CNT_W-1:0]  r_cnt;
  logic                  r_ovf;

  logic [PIO_DATA_W-1:0] w_isr_nxt;
  logic [PIO_CNT_W-1:0]  w_cnt_nxt;
  logic                  w_ovf_nxt;
  logic [PIO_CNT_W-1:0]  w_n;
  logic [PIO_CNT_W-1:0]  w_thr;
  logic [PIO_CNT_W:0]    w_sum;
  logic [PIO_CNT_W-1:0]  w_cnt_sat;
  logic [PIO_DATA_W-1:0] w_merged;
  logic                  w_ap_en;
  logic                  w_ap_fire;
  logic                  w_push_skip;

  assign w_n   = decode_count(bit_count);
  assign w_thr = decode_count(push_thresh);

  // 7-bit sum so counter+n cannot wrap before saturating at 32.
  assign w_sum     = {1'b0, r_cnt} + {1'b0, w_n};
  assign w_cnt_sat = (w_sum >= (PIO_CNT_W+1)'(PIO_DATA_W)) ? PIO_CNT_W'(PIO_DATA_W)
                                                           : w_sum[PIO_CNT_W-1:0];

`ifdef PIO_ISR_AUTOPUSH_EN
  assign w_ap_en = autopush;
`else
  assign w_ap_en = 1'b0 & autopush;
`endif

  assign w_ap_fire   = w_ap_en && (w_cnt_sat >= w_thr);
  assign w_push_skip = push_iffull && (r_cnt < w_thr);

  isr_shift_merge u_merge (
    .i_isr      (r_isr),
    .i_in_data  (in_data),
    .i_n        (w_n),
    .i_dir      (shiftdir_e'(shiftdir)),
    .o_merged_c (w_merged)
  );

  // Next-state and FIFO handshake decision; priority mov > push > in.
  always_comb begin
    w_isr_nxt  = r_isr;
    w_cnt_nxt  = r_cnt;
    w_ovf_nxt  = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    stall      = 1'b0;
    if (!rst) begin
      if (mov_en) begin
        w_isr_nxt = mov_in;
        w_cnt_nxt = '0;
      end else if (push_en) begin
        if (!w_push_skip) begin
          if (!fifo_full) begin
            fifo_push  = 1'b1;
            fifo_wdata = r_isr;
            w_isr_nxt  = '0;
            w_cnt_nxt  = '0;
          end else if (push_block) begin
            stall = 1'b1;
          end else begin
            w_isr_nxt = '0;
            w_cnt_nxt = '0;
            w_ovf_nxt = 1'b1;
          end
        end
      end else if (in_en) begin
        if (w_ap_fire) begin
          if (!fifo_full) begin
            fifo_push  = 1'b1;
            fifo_wdata = w_merged;
            w_isr_nxt  = '0;
            w_cnt_nxt  = '0;
          end else begin
            stall = 1'b1;
          end
        end else begin
          w_isr_nxt = w_merged;
          w_cnt_nxt = w_cnt_sat;
        end
      end
    end
  end

  // ISR, shift counter and overflow pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_isr <= w_isr_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign isr_out             = r_isr;
  assign input_shift_counter = r_cnt;
  assign rx_overflow         = r_ovf;

endmodule
